// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the combinational ALU slices: it registers one
// command, captures the slice result one cycle later and holds it until it is taken.
module alu_cmd_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_s,
  input  logic         alu_eq,
  input  logic         alu_cary,
  input  logic         alu_of,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_s,
  output logic         rsp_eq,
  output logic         rsp_cary,
  output logic         rsp_of,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state_q;
  logic           idle_q;
  logic           rsp_valid_q;
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [1:0]     alu_sel_q;
  logic [W-1:0]   rsp_s_q;
  logic           rsp_eq_q;
  logic           rsp_cary_q;
  logic           rsp_of_q;
  logic [15:0]    op_count_q;
  logic [15:0]    op_count_d;
  logic           arith_op;

  // Carry and overflow are only meaningful for ADD/SUB; logic slices may float them.
  assign arith_op   = alu_sel_q[1];
  assign op_count_d = op_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idle_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 2'b00;
      rsp_s_q     <= '0;
      rsp_eq_q    <= 1'b0;
      rsp_cary_q  <= 1'b0;
      rsp_of_q    <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q   <= cmd_a;
            alu_b_q   <= cmd_b;
            alu_sel_q <= cmd_op;
            idle_q    <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_s_q     <= alu_s;
          rsp_eq_q    <= alu_eq;
          rsp_cary_q  <= arith_op ? alu_cary : 1'b0;
          rsp_of_q    <= arith_op ? alu_of   : 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          idle_q      <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Held low for the whole reset window, not just from the first reset edge.
  assign cmd_ready = idle_q & ~rst;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_cary  = rsp_cary_q;
  assign rsp_of    = rsp_of_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: ALU slice environment, directed vector table,
// multi-cycle corner sequences and a randomized run against a transaction model.
module tb_alu_cmd_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_s;
  logic         alu_eq, alu_cary, alu_of;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_s;
  logic         rsp_eq, rsp_cary, rsp_of;
  logic [15:0]  op_count;
  logic         junk;

  int n_tot  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [15:0] exp_cnt;

  alu_cmd_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_s(alu_s), .alu_eq(alu_eq), .alu_cary(alu_cary), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_eq(rsp_eq), .rsp_cary(rsp_cary), .rsp_of(rsp_of),
    .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ALU slices: gate-level style carry/overflow; flags float (or carry junk) for logic ops.
  logic [W:0]   sl_sum;
  logic [W-1:0] sl_s;
  logic         sl_c, sl_of;
  always_comb begin
    sl_sum = '0;
    sl_s   = '0;
    sl_c   = 1'b0;
    sl_of  = 1'b0;
    case (alu_sel)
      2'b00: sl_s = alu_a & alu_b;
      2'b01: sl_s = alu_a | alu_b;
      2'b10: begin
        sl_sum = {1'b0, alu_a} + {1'b0, alu_b};
        sl_s   = sl_sum[W-1:0];
        sl_c   = sl_sum[W];
        sl_of  = (alu_a[W-1] == alu_b[W-1]) && (sl_s[W-1] != alu_a[W-1]);
      end
      default: begin
        sl_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
        sl_s   = sl_sum[W-1:0];
        sl_c   = sl_sum[W];
        sl_of  = (alu_a[W-1] != alu_b[W-1]) && (sl_s[W-1] != alu_a[W-1]);
      end
    endcase
    alu_s    = sl_s;
    alu_eq   = (alu_a == alu_b);
    alu_cary = alu_sel[1] ? sl_c  : (junk ? 1'b1 : 1'bz);
    alu_of   = alu_sel[1] ? sl_of : (junk ? 1'b1 : 1'bz);
  end

  // Expected response from the command alone: {s, eq, carry, overflow}.
  function automatic logic [W+2:0] ref_rsp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    logic [W-1:0] s;
    logic c, of;
    sa = $signed(a);
    sb = $signed(b);
    c  = 1'b0;
    of = 1'b0;
    case (op)
      2'b00: s = a & b;
      2'b01: s = a | b;
      2'b10: begin
        s  = a + b;
        c  = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        r  = sa + sb;
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: begin
        s  = a - b;
        c  = (a >= b);
        r  = sa - sb;
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
    endcase
    return {s, (a == b), c, of};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp"}, {rsp_s, rsp_eq, rsp_cary, rsp_of}, 0);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_sel}, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, s;
    logic         eq, c, of, jk;
  } vec_t;
  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; junk = v.jk; rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) chk($sformatf("vec%0d_ready_timeout", idx), 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("vec%0d_issue_valid", idx), rsp_valid, 0);
    chk($sformatf("vec%0d_alu_regs", idx), {alu_a, alu_b, alu_sel}, {v.a, v.b, v.op});
    @(negedge clk);
    chk($sformatf("vec%0d_resp_valid", idx), rsp_valid, 1);
    chk($sformatf("vec%0d_rsp", idx), {rsp_s, rsp_eq, rsp_cary, rsp_of}, {v.s, v.eq, v.c, v.of});
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    chk($sformatf("vec%0d_done_valid", idx), rsp_valid, 0);
    chk($sformatf("vec%0d_op_count", idx), op_count, exp_cnt);
  endtask

  initial begin
    logic [W+2:0] exp_rsp;
    logic [W-1:0] held_a;
    logic         busy;
    int           age;
    int           acc_t[$];

    vecs[0] = '{2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 32'h12345678, 32'h0F0F0000, 32'h1F3F5678, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'b10, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; junk = 1'b0; exp_cnt = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready_low", cmd_ready, 0);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // Reset landing in ISSUE.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 32'd3; cmd_b = 32'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstA_in_issue", cmd_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstA_cmd_ready_low", cmd_ready, 0);
    chk_zero_outputs("rstA");
    rst = 1'b0;
    @(negedge clk);
    chk("rstA_cmd_ready_back", cmd_ready, 1);

    // Reset landing in RESP while the response is stalled.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 32'd5; cmd_b = 32'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstB_in_resp", rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("rstB");
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstB_no_count", {rsp_valid, op_count}, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Response stall with a competing command on the input.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 32'h0000FFFF; cmd_b = 32'h12340000; rsp_ready = 1'b0; junk = 1'b1;
    @(negedge clk);
    cmd_a = $urandom; cmd_b = $urandom;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom);
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rsp_s", rsp_s, 32'h1234FFFF);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_alu_a", alu_a, 32'h0000FFFF);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_release_count", op_count, exp_cnt);
    @(negedge clk);
    @(negedge clk);
    chk("stall_single_completion", op_count, exp_cnt);
    chk("idle_holds_rsp", {rsp_s, rsp_eq, rsp_cary, rsp_of}, {32'h1234FFFF, 3'b000});

    // Randomized traffic against the transaction model.
    busy = 1'b0; age = 0; exp_rsp = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      chk("rnd_cmd_ready", cmd_ready, !busy);
      chk("rnd_rsp_valid", rsp_valid, busy && age >= 1);
      if (busy && age >= 1) chk("rnd_rsp", {rsp_s, rsp_eq, rsp_cary, rsp_of}, exp_rsp);
      chk("rnd_op_count", op_count, exp_cnt);
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      junk      = 1'($urandom);
      cmd_op    = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       begin cmd_a = $urandom; cmd_b = cmd_a; end
        1:       begin cmd_a = 32'h80000000; cmd_b = 32'($urandom_range(0, 2)); end
        2:       begin cmd_a = 32'hFFFFFFFF; cmd_b = $urandom; end
        default: begin cmd_a = $urandom; cmd_b = $urandom; end
      endcase
      if (!busy) begin
        if (cmd_valid) begin
          busy = 1'b1; age = 0; exp_rsp = ref_rsp(cmd_op, cmd_a, cmd_b);
        end
      end else if (age == 0) begin
        age = 1;
      end else if (rsp_ready) begin
        busy = 1'b0; exp_cnt = exp_cnt + 16'd1;
      end else begin
        age++;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    if (busy) exp_cnt = exp_cnt + 16'd1;
    chk("rnd_drain_count", op_count, exp_cnt);

    // Counter wrap and back-to-back acceptance spacing.
    force dut.op_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.op_count_q;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 40 && acc_t.size() < 4; k++) begin
      if (cmd_ready) acc_t.push_back(cyc);
      @(negedge clk);
      cmd_a = $urandom; cmd_b = $urandom;
    end
    cmd_valid = 1'b0;
    chk("b2b_accept_count", acc_t.size(), 4);
    for (int i = 1; i < acc_t.size(); i++) chk("b2b_accept_spacing", acc_t[i] - acc_t[i-1], 3);
    chk("wrap_to_zero", op_count, 16'h0000);
    repeat (3) @(negedge clk);
    chk("wrap_after_one", op_count, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
